i2c_master_drv: RTL and testbench

- Single-byte I2C master serving the ADC/DAC controller and other I2C peripheral controllers (EEPROM, RTC) through the existing i2c_exec/i2c_done command interface.
- Takes one command at a time (write or random read, 8- or 16-bit word address). Serialises it onto SCL/SDA and returns read data plus a done pulse.
- Everything runs on one system clock. SCL timing comes from an internal tick, not a derived clock.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_tick_gen.sv | 51 +++++
 rtl/i2c_master_drv.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_master_drv.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    SLA_W   = 4'd2,
    ADDR_H  = 4'd3,
    ADDR_L  = 4'd4,
    DATA_WR = 4'd5,
    RESTART = 4'd6,
    SLA_R   = 4'd7,
    DATA_RD = 4'd8,
    STOP    = 4'd9,
    DONE    = 4'd10
  } i2c_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Quarter phases of one bit period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Clocks per quarter bit (four ticks make one SCL period)
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned i2c_freq);
    return clk_freq / (32'd4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle tick every DIV clocks plus a
// 2-bit quarter-phase counter. Both are held at zero while clr is high.
`timescale 1ns/1ps
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Divider counter: wraps at DIV-1, cleared while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  // Quarter-phase counter advances on every tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quarter <= Q0;
    end else if (clr) begin
      quarter <= Q0;
    end else if (tick) begin
      quarter <= quarter + 2'd1;
    end else begin
      quarter <= quarter;
    end
  end

endmodule

// File: rtl/i2c_master_drv.sv
// Single-byte I2C master: write or random read with 8/16-bit word address.
// SCL/SDA are registered; SDA is open-drain (drive 0 or release).
`timescale 1ns/1ps
module i2c_master_drv
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1001000,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_exec,
  input  logic        bit_ctrl,
  input  logic        i2c_rh_wl,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_data_w,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        busy,
  output logic        scl,
  inout  wire         sda
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, I2C_FREQ);

  i2c_state_t  state, state_next;
  logic        tick;
  logic [1:0]  quarter;
  logic        tick_en, tick_clr;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic        ack_err, ack_err_next;
  logic [7:0]  rx_sh, rx_sh_next;
  logic        cmd_rw, cmd_bc;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        sda_meta, sda_sync;
  logic        sda_low, sda_low_next, scl_next;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  assign tick_en  = (state != IDLE);
  assign tick_clr = (state == IDLE);
  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign tx_bit   = tx_byte[3'd7 - bit_cnt[2:0]];

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (tick_en),
    .clr     (tick_clr),
    .tick    (tick),
    .quarter (quarter)
  );

  // Two-flop synchroniser on the incoming SDA line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda;
      sda_sync <= sda_meta;
    end
  end

  // Latch the command when a request arrives in IDLE; ignored otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rw   <= RW_WRITE;
      cmd_bc   <= 1'b0;
      cmd_addr <= 16'h0000;
      cmd_data <= 8'h00;
    end else if (state == IDLE && i2c_exec) begin
      cmd_rw   <= i2c_rh_wl;
      cmd_bc   <= bit_ctrl;
      cmd_addr <= i2c_addr;
      cmd_data <= i2c_data_w;
    end else begin
      cmd_rw   <= cmd_rw;
      cmd_bc   <= cmd_bc;
      cmd_addr <= cmd_addr;
      cmd_data <= cmd_data;
    end
  end

  // Byte to serialise in the current state; all-ones releases SDA
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      SLA_W:   tx_byte = {SLAVE_ADDR, RW_WRITE};
      ADDR_H:  tx_byte = cmd_addr[15:8];
      ADDR_L:  tx_byte = cmd_addr[7:0];
      DATA_WR: tx_byte = cmd_data;
      SLA_R:   tx_byte = {SLAVE_ADDR, RW_READ};
      default: tx_byte = 8'hFF;
    endcase
  end

  // FSM state, bit counter, NACK flag and receive shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      ack_err <= 1'b0;
      rx_sh   <= 8'h00;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      ack_err <= ack_err_next;
      rx_sh   <= rx_sh_next;
    end
  end

  // Next-state logic: bytes are 9 bits, ACK sampled at q2, moves at q3
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    ack_err_next = ack_err;
    rx_sh_next   = rx_sh;
    case (state)
      IDLE: begin
        bit_cnt_next = 4'd0;
        if (i2c_exec) begin
          state_next   = START;
          ack_err_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (tick && quarter == Q3) state_next = SLA_W;
        else                       state_next = START;
      end
      RESTART: begin
        if (tick && quarter == Q3) state_next = SLA_R;
        else                       state_next = RESTART;
      end
      SLA_W, ADDR_H, ADDR_L, DATA_WR, SLA_R, DATA_RD: begin
        if (tick && quarter == Q2) begin
          if (bit_cnt == 4'd8) begin
            // Master NACK slot after DATA_RD is not a slave acknowledge
            if (state != DATA_RD && sda_sync) ack_err_next = 1'b1;
            else                              ack_err_next = ack_err;
          end else if (state == DATA_RD) begin
            rx_sh_next = {rx_sh[6:0], sda_sync};
          end else begin
            rx_sh_next = rx_sh;
          end
        end else if (tick && quarter == Q3) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt_next = 4'd0;
            if (ack_err) begin
              state_next = STOP;
            end else begin
              case (state)
                SLA_W:   state_next = cmd_bc ? ADDR_H : ADDR_L;
                ADDR_H:  state_next = ADDR_L;
                ADDR_L:  state_next = (cmd_rw == RW_READ) ? RESTART : DATA_WR;
                SLA_R:   state_next = DATA_RD;
                default: state_next = STOP;
              endcase
            end
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else begin
          state_next = state;
        end
      end
      STOP: begin
        if (tick && quarter == Q3) state_next = DONE;
        else                       state_next = STOP;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus waveform per state and quarter phase
  always_comb begin
    scl_next     = 1'b1;
    sda_low_next = 1'b0;
    case (state)
      START: begin
        scl_next     = (quarter != Q3);
        sda_low_next = (quarter == Q2) || (quarter == Q3);
      end
      RESTART: begin
        scl_next     = (quarter == Q1) || (quarter == Q2);
        sda_low_next = (quarter == Q2) || (quarter == Q3);
      end
      SLA_W, ADDR_H, ADDR_L, DATA_WR, SLA_R, DATA_RD: begin
        scl_next     = (quarter == Q1) || (quarter == Q2);
        sda_low_next = (bit_cnt < 4'd8) && !tx_bit;
      end
      STOP: begin
        scl_next     = (quarter != Q0);
        sda_low_next = (quarter == Q0) || (quarter == Q1);
      end
      default: begin
        scl_next     = 1'b1;
        sda_low_next = 1'b0;
      end
    endcase
  end

  // Registered bus drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl     <= 1'b1;
      sda_low <= 1'b0;
    end else begin
      scl     <= scl_next;
      sda_low <= sda_low_next;
    end
  end

  // Registered status: done/busy track the DONE state, results latched on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2c_done   <= 1'b0;
      busy       <= 1'b0;
      i2c_ack    <= 1'b0;
      i2c_data_r <= 8'h00;
    end else begin
      i2c_done <= (state_next == DONE);
      busy     <= (state_next != IDLE) && (state_next != DONE);
      if (state == STOP && state_next == DONE) begin
        i2c_ack <= ack_err;
        if (cmd_rw == RW_READ && !ack_err) i2c_data_r <= rx_sh;
        else                               i2c_data_r <= i2c_data_r;
      end else begin
        i2c_ack    <= i2c_ack;
        i2c_data_r <= i2c_data_r;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_drv.sv
// Self-checking bench for i2c_master_drv: bus-level slave model plus a
// transaction-level reference that predicts bytes, latency and results.
`timescale 1ns/1ps
module tb_i2c_master_drv;

  localparam int          DIV = 50;
  localparam logic [6:0]  SLV = 7'h48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2c_exec = 1'b0;
  logic        bit_ctrl = 1'b0;
  logic        i2c_rh_wl = 1'b0;
  logic [15:0] i2c_addr = 16'h0000;
  logic [7:0]  i2c_data_w = 8'h00;
  logic [7:0]  i2c_data_r;
  logic        i2c_done, i2c_ack, busy, scl;
  wire         sda;

  pullup (sda);

  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_drv dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_exec   (i2c_exec),
    .bit_ctrl   (bit_ctrl),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .i2c_data_r (i2c_data_r),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .busy       (busy),
    .scl        (scl),
    .sda        (sda)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [7:0] log_q[$];
  int   start_cnt = 0, stop_cnt = 0, done_cnt = 0;
  int   nack_idx = -1;
  logic [7:0] rd_byte = 8'h00;
  logic master_nack = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  int   bitcnt = 0;
  logic [7:0] sh = 8'h00;
  bit   reading = 0, pend_read = 0, first = 0;

  always @(negedge clk) begin
    if (i2c_done) done_cnt++;
  end

  always @(negedge clk) begin
    if (rst) begin
      slv_low = 1'b0; bitcnt = 0; reading = 0; pend_read = 0; first = 0;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      start_cnt++; bitcnt = 0; reading = 0; pend_read = 0; first = 1; slv_low = 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stop_cnt++; bitcnt = 0; reading = 0; slv_low = 1'b0;
    end else if (!prev_scl && scl) begin
      if (bitcnt < 8) begin
        if (!reading) sh = {sh[6:0], sda};
      end else if (reading) begin
        master_nack = sda;
      end
      bitcnt++;
    end else if (prev_scl && !scl) begin
      if (bitcnt == 8) begin
        if (!reading) begin
          log_q.push_back(sh);
          slv_low = ((int'(log_q.size()) - 1) != nack_idx);
          if (first && sh[0] && slv_low) pend_read = 1;
          first = 0;
        end else begin
          slv_low = 1'b0;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0; reading = 0; slv_low = 1'b0;
        if (pend_read) begin
          pend_read = 0; reading = 1; slv_low = !rd_byte[7];
        end
      end else if (reading && bitcnt >= 1 && bitcnt <= 7) begin
        slv_low = !rd_byte[7 - bitcnt];
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // ---------------- reference + driver ----------------
  logic [7:0] exp_data_r = 8'h00;

  task automatic run_txn(input logic rw, input logic bc, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rbyte,
                         input int nidx, input int extra_at);
    int seg[$];
    logic [7:0] exp_b[$];
    int ticks, starts, cyc, exp_lat;
    bit nacked, got;
    // Transaction-level model: segments -1 = repeated start, -2 = read byte
    seg.push_back(int'({SLV, 1'b0}));
    if (bc) seg.push_back(int'(addr[15:8]));
    seg.push_back(int'(addr[7:0]));
    if (!rw) seg.push_back(int'(wdata));
    else begin
      seg.push_back(-1); seg.push_back(int'({SLV, 1'b1})); seg.push_back(-2);
    end
    ticks = 4; starts = 1; nacked = 0;
    foreach (seg[i]) begin
      if (!nacked) begin
        if (seg[i] == -1) begin ticks += 4; starts++; end
        else if (seg[i] == -2) ticks += 36;
        else begin
          ticks += 36;
          exp_b.push_back(seg[i][7:0]);
          if (int'(exp_b.size()) - 1 == nidx) nacked = 1;
        end
      end
    end
    ticks += 4;
    exp_lat = ticks * DIV;
    if (rw && !nacked) exp_data_r = rbyte;

    log_q = {}; start_cnt = 0; stop_cnt = 0; done_cnt = 0;
    nack_idx = nidx; rd_byte = rbyte; master_nack = 1'b0;

    @(negedge clk);
    i2c_rh_wl = rw; bit_ctrl = bc; i2c_addr = addr; i2c_data_w = wdata; i2c_exec = 1'b1;
    @(posedge clk); #1;
    i2c_exec = 1'b0;
    check_eq("busy_set", busy, 1);
    cyc = 0; got = 0;
    while (!got && cyc < exp_lat + 200) begin
      @(posedge clk); cyc++; #1;
      if (cyc == extra_at && extra_at > 0) begin
        check_eq("busy_mid", busy, 1);
        i2c_exec = 1'b1; i2c_rh_wl = ~rw; bit_ctrl = ~bc; i2c_addr = ~addr; i2c_data_w = ~wdata;
      end else begin
        i2c_exec = 1'b0;
      end
      if (i2c_done) got = 1;
    end
    i2c_exec = 1'b0;
    check_eq("done_seen", got, 1);
    check_eq($sformatf("latency %0d vs %0d", cyc, exp_lat),
             (cyc >= exp_lat - 2) && (cyc <= exp_lat + 2), 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("ack", i2c_ack, nacked);
    check_eq("data_r", i2c_data_r, exp_data_r);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_pulses", done_cnt, 1);
    check_eq("byte_count", log_q.size(), exp_b.size());
    foreach (exp_b[i]) begin
      if (i < log_q.size()) check_eq($sformatf("byte%0d", i), log_q[i], exp_b[i]);
    end
    check_eq("starts", start_cnt, starts);
    check_eq("stops", stop_cnt, 1);
    if (rw && !nacked) check_eq("master_nack", master_nack, 1);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_scl", scl, 1);
    check_eq("rst_sda", sda, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", i2c_done, 0);
    check_eq("rst_ack", i2c_ack, 0);
    check_eq("rst_data_r", i2c_data_r, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);

    run_txn(1'b0, 1'b0, 16'h0040, 8'hA5, 8'h00, -1, 0);   // 8-bit write
    run_txn(1'b1, 1'b0, 16'h0040, 8'h00, 8'h7E, -1, 0);   // 8-bit read
    run_txn(1'b0, 1'b1, 16'h1234, 8'h5A, 8'h00, -1, 0);   // 16-bit write
    run_txn(1'b0, 1'b0, 16'h0040, 8'h33, 8'h00, 0, 0);    // NACK on SLA_W
    run_txn(1'b0, 1'b0, 16'h0021, 8'hC3, 8'h00, -1, 1000);// exec while busy

    // Reset abort during DATA_WR
    done_cnt = 0;
    @(negedge clk);
    i2c_rh_wl = 1'b0; bit_ctrl = 1'b0; i2c_addr = 16'h0055; i2c_data_w = 8'h0F; i2c_exec = 1'b1;
    @(negedge clk); i2c_exec = 1'b0;
    repeat (4500) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check_eq("abort_scl", scl, 1);
    check_eq("abort_sda", sda, 1);
    check_eq("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    exp_data_r = 8'h00;
    repeat (200) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_ack", i2c_ack, 0);
    run_txn(1'b0, 1'b0, 16'h0055, 8'h0F, 8'h00, -1, 0);   // after reset

    for (int t = 0; t < 3; t++) begin
      logic rw, bc;
      int nb, nidx;
      rw = 1'($urandom_range(0, 1));
      bc = 1'($urandom_range(0, 1));
      nb = 3 + int'(bc);
      nidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_txn(rw, bc, 16'($urandom), 8'($urandom), 8'($urandom), nidx, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
